// File: rtl/alu_scheduler.sv
// Two-requester front end for a shared combinational ALU: round-robin grant, multi-pass
// shift sequencing and a held response with valid/ready handshake.
module alu_scheduler #(
  parameter int unsigned NREQ = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic       req1_valid,
  output logic       req0_ready,
  output logic       req1_ready,
  input  logic [3:0] req0_mode,
  input  logic [3:0] req1_mode,
  input  logic [7:0] req0_op1,
  input  logic [7:0] req0_op2,
  input  logic [7:0] req1_op1,
  input  logic [7:0] req1_op2,
  output logic [3:0] alu_mode,
  output logic [7:0] alu_op1,
  output logic [7:0] alu_op2,
  input  logic [7:0] alu_result,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [7:0] rsp_data,
  output logic       busy
);

  if (NREQ != 2) begin : g_bad_nreq
    $error("alu_scheduler supports exactly two requesters");
  end

  localparam logic [3:0] ModeNop = 4'b0000;
  localparam logic [3:0] ModeShl = 4'b0111;
  localparam logic [3:0] ModeShr = 4'b1000;

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e      r_state;
  state_e      w_state_d;
  logic        r_ptr;
  logic        r_id;
  logic [3:0]  r_mode;
  logic [7:0]  r_op1;
  logic [7:0]  r_op2;
  logic [2:0]  r_cnt;
  logic [7:0]  r_acc;
  logic [7:0]  r_data;

  logic        w_grant0;
  logic        w_grant1;
  logic        w_accept;
  logic        w_shift;
  logic [2:0]  w_n;
  logic        w_last;
  logic [7:0]  w_capture;

  // The pointer only breaks ties; a lone valid requester always wins.
  always_comb begin
    w_grant0 = req0_valid & (~req1_valid | ~r_ptr);
    w_grant1 = req1_valid & (~req0_valid | r_ptr);
    w_accept = (r_state == StIdle) & (w_grant0 | w_grant1);
  end

  always_comb begin
    w_shift   = (r_mode == ModeShl) || (r_mode == ModeShr);
    w_n       = r_op2[2:0];
    w_last    = !w_shift || (w_n == 3'd0) || (r_cnt == w_n - 3'd1);
    // A zero-count shift is a pass-through of the latched operand.
    w_capture = (w_shift && (w_n == 3'd0)) ? r_op1 : alu_result;
  end

  always_comb begin
    w_state_d  = r_state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    alu_mode   = ModeNop;
    alu_op1    = 8'h00;
    alu_op2    = 8'h00;
    rsp_valid  = 1'b0;
    unique case (r_state)
      StIdle: begin
        req0_ready = w_grant0;
        req1_ready = w_grant1;
        if (w_accept) w_state_d = StExec;
      end
      StExec: begin
        if (w_shift) begin
          if (w_n == 3'd0) begin
            alu_op1 = r_op1;
          end else begin
            alu_mode = r_mode;
            alu_op1  = (r_cnt == 3'd0) ? r_op1 : r_acc;
          end
        end else begin
          alu_mode = r_mode;
          alu_op1  = r_op1;
          alu_op2  = r_op2;
        end
        if (w_last) w_state_d = StResp;
      end
      StResp: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_ptr   <= 1'b0;
      r_id    <= 1'b0;
      r_mode  <= 4'h0;
      r_op1   <= 8'h00;
      r_op2   <= 8'h00;
      r_cnt   <= 3'd0;
      r_acc   <= 8'h00;
      r_data  <= 8'h00;
    end else begin
      r_state <= w_state_d;
      if (w_accept) begin
        r_id   <= w_grant1;
        r_ptr  <= ~w_grant1;
        r_mode <= w_grant1 ? req1_mode : req0_mode;
        r_op1  <= w_grant1 ? req1_op1 : req0_op1;
        r_op2  <= w_grant1 ? req1_op2 : req0_op2;
        r_cnt  <= 3'd0;
      end
      if (r_state == StExec) begin
        r_acc <= alu_result;
        r_cnt <= r_cnt + 3'd1;
        if (w_last) r_data <= w_capture;
      end
    end
  end

  assign rsp_id   = r_id;
  assign rsp_data = r_data;
  assign busy     = (r_state != StIdle);

endmodule

// File: tb/tb_alu_scheduler.sv
// Directed and randomized checks of alu_scheduler against a result/latency/arbitration model;
// the shared ALU is modelled here as combinational logic.
module tb_alu_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic       req0_ready, req1_ready;
  logic [3:0] req0_mode = 4'h0, req1_mode = 4'h0;
  logic [7:0] req0_op1 = 8'h00, req0_op2 = 8'h00, req1_op1 = 8'h00, req1_op2 = 8'h00;
  logic [3:0] alu_mode;
  logic [7:0] alu_op1, alu_op2, alu_result;
  logic       rsp_valid, rsp_id, busy;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_data;

  int total = 0;
  int bad   = 0;
  int ptr   = 0;
  int gid;

  always #5 clk = ~clk;

  alu_scheduler #(.NREQ(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_mode(req0_mode), .req1_mode(req1_mode),
    .req0_op1(req0_op1), .req0_op2(req0_op2),
    .req1_op1(req1_op1), .req1_op2(req1_op2),
    .alu_mode(alu_mode), .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .busy(busy)
  );

  function automatic logic [7:0] alu_fn(input logic [3:0] m, input logic [7:0] a,
                                        input logic [7:0] b);
    case (m)
      4'd1, 4'd9: return a + b;
      4'd2, 4'd4: return b;
      4'd3:       return a;
      4'd5:       return a ^ b;
      4'd6:       return a & b;
      4'd7:       return a << 1;
      4'd8:       return a >> 1;
      default:    return 8'h00;
    endcase
  endfunction

  always_comb alu_result = alu_fn(alu_mode, alu_op1, alu_op2);

  function automatic logic [7:0] ref_result(input logic [3:0] m, input logic [7:0] a,
                                            input logic [7:0] b);
    logic [7:0] r;
    r = a;
    if (m == 4'd7) r = a << b[2:0];
    else if (m == 4'd8) r = a >> b[2:0];
    else r = alu_fn(m, a, b);
    return r;
  endfunction

  function automatic int ref_lat(input logic [3:0] m, input logic [7:0] b);
    int n;
    n = int'(b[2:0]);
    if (m == 4'd7 || m == 4'd8) return 1 + ((n < 1) ? 1 : n);
    return 2;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_id"}, rsp_id, 0);
    check({tag, "_rsp_data"}, rsp_data, 0);
    check({tag, "_alu_mode"}, alu_mode, 0);
    check({tag, "_alu_op1"}, alu_op1, 0);
    check({tag, "_alu_op2"}, alu_op2, 0);
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst_n = 1'b0;
    ptr = 0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
  endtask

  // One full operation: arbitration, latency, response, backpressure and handshake.
  task automatic transact(input bit v0, input bit v1,
                          input logic [3:0] m0, input logic [7:0] a0, input logic [7:0] b0,
                          input logic [3:0] m1, input logic [7:0] a1, input logic [7:0] b1,
                          input int bp, output int g);
    int lat;
    logic [3:0] m;
    logic [7:0] a, b, exp_d;
    req0_valid = v0; req0_mode = m0; req0_op1 = a0; req0_op2 = b0;
    req1_valid = v1; req1_mode = m1; req1_op1 = a1; req1_op2 = b1;
    #1;
    g = (v0 && v1) ? ptr : (v1 ? 1 : 0);
    check("grant_ready0", req0_ready, (g == 0));
    check("grant_ready1", req1_ready, (g == 1));
    m = (g == 1) ? m1 : m0;
    a = (g == 1) ? a1 : a0;
    b = (g == 1) ? b1 : b0;
    exp_d = ref_result(m, a, b);
    cyc();
    ptr = 1 - g;
    req0_valid = 1'($urandom); req1_valid = 1'($urandom);
    req0_op1 = 8'($urandom); req0_op2 = 8'($urandom); req0_mode = 4'($urandom);
    req1_op1 = 8'($urandom); req1_op2 = 8'($urandom); req1_mode = 4'($urandom);
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      cyc();
      lat++;
    end
    check("latency", lat, ref_lat(m, b));
    check("rsp_id", rsp_id, g);
    check("rsp_data", rsp_data, exp_d);
    for (int i = 0; i < bp; i++) begin
      cyc();
      check("bp_valid", rsp_valid, 1);
      check("bp_data", rsp_data, exp_d);
      check("bp_ready0", req0_ready, 0);
      check("bp_ready1", req1_ready, 0);
    end
    rsp_ready = 1'b1;
    #1;
    check("hs_ready0", req0_ready, 0);
    check("hs_ready1", req1_ready, 0);
    cyc();
    rsp_ready = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    check("post_hs_busy", busy, 0);
    check("post_hs_valid", rsp_valid, 0);
    check("post_hs_data", rsp_data, exp_d);
  endtask

  initial begin
    // Reset held: everything quiet.
    #12;
    check_all_zero("reset");
    check("reset_ready0", req0_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();

    // Single ADD with cycle-level view of the ALU drive.
    req0_valid = 1'b1; req0_mode = 4'd1; req0_op1 = 8'h12; req0_op2 = 8'h34;
    #1;
    check("add_ready0", req0_ready, 1);
    check("add_ready1", req1_ready, 0);
    cyc();
    ptr = 1;
    req0_valid = 1'b0;
    check("add_alu_mode", alu_mode, 4'd1);
    check("add_alu_op1", alu_op1, 8'h12);
    check("add_alu_op2", alu_op2, 8'h34);
    check("add_busy", busy, 1);
    check("add_exec_valid", rsp_valid, 0);
    cyc();
    check("add_rsp_valid", rsp_valid, 1);
    check("add_rsp_id", rsp_id, 0);
    check("add_rsp_data", rsp_data, 8'h46);
    check("add_resp_alu_mode", alu_mode, 0);
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;
    check("add_idle_busy", busy, 0);
    check("add_retain", rsp_data, 8'h46);

    // SHL by 3 from requester 1; inputs disturbed mid-operation.
    req1_valid = 1'b1; req1_mode = 4'd7; req1_op1 = 8'h03; req1_op2 = 8'h03;
    #1;
    check("shl_ready1", req1_ready, 1);
    cyc();
    ptr = 0;
    req1_valid = 1'b0; req1_op1 = 8'hFF; req1_op2 = 8'h07; req1_mode = 4'd1;
    for (int i = 0; i < 3; i++) begin
      check("shl_alu_mode", alu_mode, 4'd7);
      check("shl_alu_op1", alu_op1, 8'h03 << i);
      check("shl_alu_op2", alu_op2, 0);
      check("shl_no_valid", rsp_valid, 0);
      cyc();
    end
    check("shl_rsp_valid", rsp_valid, 1);
    check("shl_rsp_data", rsp_data, 8'h18);
    check("shl_rsp_id", rsp_id, 1);
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;

    // SHR n=0, wrap-around ADD, undefined mode, then backpressure with both valid.
    transact(1, 0, 4'd8, 8'hA5, 8'h08, 4'd0, 8'h00, 8'h00, 0, gid);
    transact(1, 0, 4'd1, 8'hFF, 8'h01, 4'd0, 8'h00, 8'h00, 0, gid);
    transact(0, 1, 4'd0, 8'h00, 8'h00, 4'hF, 8'h5A, 8'hC3, 0, gid);
    transact(1, 1, 4'd5, 8'hF0, 8'h3C, 4'd6, 8'hF0, 8'h3C, 5, gid);

    // Round-robin fairness straight after reset.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      transact(1, 1, 4'd9, 8'(i), 8'h10, 4'd3, 8'(i + 8), 8'h01, 1, gid);
      check("rr_grant", gid, i % 2);
    end
    do_reset();
    transact(0, 1, 4'd1, 8'h01, 8'h01, 4'd2, 8'h11, 8'h22, 0, gid);
    check("sole_req1", gid, 1);

    // Asynchronous reset in the second pass of a 5-step shift.
    do_reset();
    req0_valid = 1'b1; req0_mode = 4'd7; req0_op1 = 8'h01; req0_op2 = 8'h05;
    cyc();
    req0_valid = 1'b0;
    cyc();
    check("midshift_busy", busy, 1);
    #2;
    rst_n = 1'b0;
    ptr = 0;
    #1;
    check_all_zero("midshift_rst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc();
      check("midshift_no_rsp", rsp_valid, 0);
    end
    transact(1, 1, 4'd1, 8'h20, 8'h02, 4'd1, 8'h30, 8'h03, 0, gid);
    check("midshift_grant0", gid, 0);

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      bit v0, v1;
      v0 = 1'($urandom);
      v1 = v0 ? 1'($urandom) : 1'b1;
      transact(v0, v1, 4'($urandom), 8'($urandom), 8'($urandom),
               4'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(0, 3)), gid);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
